// File: rtl/filter_pad_sequencer_pkg.sv
// rtl/filter_pad_sequencer_pkg.sv - shared types and geometry helpers for the pad sequencer
package filter_pad_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TOP,
    LEFT,
    DATA,
    RIGHT,
    BOTTOM,
    DONE
  } seqState_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  function automatic int padBorder(input int kernelSize);
    return (kernelSize - 1) / 2;
  endfunction

  function automatic int padW(input int width, input int kernelSize);
    return width + 2 * padBorder(kernelSize);
  endfunction

  function automatic int padH(input int height, input int kernelSize);
    return height + 2 * padBorder(kernelSize);
  endfunction

endpackage

// File: rtl/filter_pad_sequencer_if.sv
// rtl/filter_pad_sequencer_if.sv - demosaic-side input and filter-side output pixel streams
interface filter_pad_sequencer_if;
  import filter_pad_sequencer_pkg::*;

  logic        iValid;
  logic [7:0]  iR;
  logic [7:0]  iG;
  logic [7:0]  iB;
  pixel_t      oData;
  logic        oValid;
  logic [15:0] oX;
  logic [15:0] oY;

  modport master (output iValid, iR, iG, iB, input oData, oValid, oX, oY);
  modport slave  (input iValid, iR, iG, iB, output oData, oValid, oX, oY);

endinterface

// File: rtl/filter_pad_sequencer_fifo.sv
// rtl/filter_pad_sequencer_fifo.sv - 24-bit pixel FIFO, first-word latency of one cycle
module sync_fifo_24
  import filter_pad_sequencer_pkg::*;
#(
  parameter int depth = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wrEn,
  input  pixel_t                 wrData,
  input  logic                   rdEn,
  output pixel_t                 rdData,
  output logic                   empty,
  output logic                   drop,
  output logic [$clog2(depth):0] level
);
  localparam int AW = $clog2(depth);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(depth);

  pixel_t          mem [depth];
  logic [AW-1:0]   wrPtr;
  logic [AW-1:0]   rdPtr;
  logic            full;
  logic            doWrite;
  logic            doRead;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign doRead  = rdEn && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign doWrite = wrEn && (!full || doRead);
  assign drop    = wrEn && full && !doRead;
  assign rdData  = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      level <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + AW'(1);
      if (doRead)  rdPtr <= rdPtr + AW'(1);
      if (doWrite && !doRead)      level <= level + (AW + 1)'(1);
      else if (!doWrite && doRead) level <= level - (AW + 1)'(1);
    end
  end

endmodule

// File: rtl/filter_pad_sequencer.sv
// rtl/filter_pad_sequencer.sv - buffers demosaiced pixels and emits a zero-padded frame to the filter
module filter_pad_sequencer
  import filter_pad_sequencer_pkg::*;
#(
  parameter int width      = 320,
  parameter int height     = 240,
  parameter int kernelSize = 7,
  parameter int fifoDepth  = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   newFrame,
  filter_pad_sequencer_if.slave  bus,
  output logic                   oDone,
  output logic                   oOverflow,
  output logic [15:0]            oFifoLevel
);
  localparam int B = padBorder(kernelSize);
  localparam logic [15:0] LAST_X        = 16'(padW(width, kernelSize) - 1);
  localparam logic [15:0] LAST_Y        = 16'(padH(height, kernelSize) - 1);
  localparam logic [15:0] TOP_END_Y     = 16'(B - 1);
  localparam logic [15:0] LEFT_END_X    = 16'(B - 1);
  localparam logic [15:0] DATA_END_X    = 16'(B + width - 1);
  localparam logic [15:0] LAST_ACTIVE_Y = 16'(B + height - 1);

  seqState_t state;
  seqState_t nextState;
  logic [15:0] x;
  logic [15:0] y;
  logic        pending;
  logic        emit;
  logic        pop;
  logic        fifoEmpty;
  logic        fifoDrop;
  pixel_t      fifoData;
  pixel_t      emitPixel;
  pixel_t      wrPixel;
  logic [$clog2(fifoDepth):0] fifoLevel;

  assign wrPixel    = '{r: bus.iR, g: bus.iG, b: bus.iB};
  assign oFifoLevel = 16'(fifoLevel);

  sync_fifo_24 #(.depth(fifoDepth)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wrEn   (bus.iValid),
    .wrData (wrPixel),
    .rdEn   (pop),
    .rdData (fifoData),
    .empty  (fifoEmpty),
    .drop   (fifoDrop),
    .level  (fifoLevel)
  );

  always_comb begin
    nextState = state;
    emit      = 1'b0;
    pop       = 1'b0;
    emitPixel = '0;
    case (state)
      IDLE: if (newFrame) nextState = TOP;
      TOP: begin
        emit = 1'b1;
        if (x == LAST_X && y == TOP_END_Y) nextState = LEFT;
      end
      LEFT: begin
        emit = 1'b1;
        if (x == LEFT_END_X) nextState = DATA;
      end
      DATA: begin
        if (!fifoEmpty) begin
          emit      = 1'b1;
          pop       = 1'b1;
          emitPixel = fifoData;
          if (x == DATA_END_X) nextState = RIGHT;
        end
      end
      RIGHT: begin
        emit = 1'b1;
        if (x == LAST_X) nextState = (y == LAST_ACTIVE_Y) ? BOTTOM : LEFT;
      end
      BOTTOM: begin
        emit = 1'b1;
        if (x == LAST_X && y == LAST_Y) nextState = DONE;
      end
      DONE:    nextState = (pending || newFrame) ? TOP : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // x/y wrap back to 0 after the last padded pixel, so every frame starts at the origin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x          <= '0;
      y          <= '0;
      pending    <= 1'b0;
      bus.oValid <= 1'b0;
      bus.oData  <= '0;
      bus.oX     <= '0;
      bus.oY     <= '0;
      oDone      <= 1'b0;
      oOverflow  <= 1'b0;
    end else begin
      bus.oValid <= emit;
      bus.oData  <= emitPixel;
      oDone      <= (state == DONE);
      if (fifoDrop) oOverflow <= 1'b1;
      if (state == DONE)                     pending <= 1'b0;
      else if (newFrame && state != IDLE)    pending <= 1'b1;
      if (emit) begin
        bus.oX <= x;
        bus.oY <= y;
        if (x == LAST_X) begin
          x <= '0;
          y <= (y == LAST_Y) ? 16'd0 : y + 16'd1;
        end else begin
          x <= x + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_filter_pad_sequencer.sv
// tb/tb_filter_pad_sequencer.sv - self-checking bench for filter_pad_sequencer
module tb_filter_pad_sequencer;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int K     = 3;
  localparam int D     = 16;
  localparam int BD    = (K - 1) / 2;
  localparam int PW    = W + 2 * BD;
  localparam int PH    = H + 2 * BD;
  localparam int FRAME = PW * PH;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        newFrame = 1'b0;
  logic        oDone;
  logic        oOverflow;
  logic [15:0] oFifoLevel;

  filter_pad_sequencer_if bus();

  filter_pad_sequencer #(
    .width(W), .height(H), .kernelSize(K), .fifoDepth(D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .newFrame   (newFrame),
    .bus        (bus),
    .oDone      (oDone),
    .oOverflow  (oOverflow),
    .oFifoLevel (oFifoLevel)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int firstV, lastV, doneCyc;
  logic [55:0] capQ[$];
  logic [23:0] modelQ[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [23:0] pix, input logic nf);
    bus.iValid = v;
    {bus.iR, bus.iG, bus.iB} = pix;
    newFrame = nf;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.oValid) begin
      capQ.push_back({bus.oX, bus.oY, bus.oData});
      if (firstV < 0) firstV = cyc;
      lastV = cyc;
    end
    if (oDone && doneCyc < 0) doneCyc = cyc;
  endtask

  task automatic clearCap();
    capQ.delete();
    firstV  = -1;
    lastV   = -1;
    doneCyc = -1;
  endtask

  task automatic pushRand(input int n, input int keep);
    logic [23:0] p;
    for (int i = 0; i < n; i++) begin
      p = 24'($urandom);
      step(1'b1, p, 1'b0);
      if (i < keep) modelQ.push_back(p);
    end
    step(1'b0, 24'h0, 1'b0);
  endtask

  task automatic doReset();
    bus.iValid = 1'b0;
    newFrame   = 1'b0;
    #2 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    modelQ.delete();
  endtask

  task automatic runFrame(input bit nf, input bit trickle, input bit nfInBottom);
    int n;
    int left;
    bit injected;
    logic v, f;
    logic [23:0] p;
    logic [55:0] lastCap;
    n = 0;
    left = W * H;
    injected = 0;
    while (doneCyc < 0 && n < 300) begin
      v = 1'b0;
      f = 1'b0;
      p = 24'h0;
      if (n == 0 && nf) f = 1'b1;
      if (trickle && (n % 3) == 0 && left > 0) begin
        v = 1'b1;
        p = 24'($urandom);
        modelQ.push_back(p);
        left--;
      end
      if (nfInBottom && !injected && capQ.size() > 0) begin
        lastCap = capQ[capQ.size() - 1];
        if (lastCap[39:24] == 16'(PH - 1)) begin
          f = 1'b1;
          injected = 1;
        end
      end
      step(v, p, f);
      n++;
    end
  endtask

  // Reference: padded raster scan, active window consumes input pixels in arrival order.
  task automatic checkFrame(input string tag, input bit contiguous);
    logic [55:0] exp;
    logic [23:0] d;
    int k;
    k = 0;
    check({tag, ".count"}, 64'(capQ.size()), 64'(FRAME));
    for (int py = 0; py < PH; py++) begin
      for (int px = 0; px < PW; px++) begin
        d = 24'h0;
        if (px >= BD && px < BD + W && py >= BD && py < BD + H && modelQ.size() > 0)
          d = modelQ.pop_front();
        exp = {16'(px), 16'(py), d};
        if (k < capQ.size()) check($sformatf("%s.pix%0d", tag, k), capQ[k], exp);
        k++;
      end
    end
    check({tag, ".doneTiming"}, 64'(doneCyc), 64'(lastV + 1));
    if (contiguous) check({tag, ".contiguous"}, 64'(lastV - firstV + 1), 64'(FRAME));
    else            check({tag, ".bubbles"}, 64'((lastV - firstV + 1) > FRAME), 64'(1));
  endtask

  task automatic waitDataEntry(input string tag);
    bit found;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (bus.oValid && bus.oX == 16'(BD - 1) && bus.oY == 16'(BD)) found = 1;
      else step(1'b0, 24'h0, 1'b0);
    end
    check({tag, ".reachedData"}, 64'(found), 64'(1));
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".oData"},      64'(bus.oData),  64'(0));
    check({tag, ".oValid"},     64'(bus.oValid), 64'(0));
    check({tag, ".oX"},         64'(bus.oX),     64'(0));
    check({tag, ".oY"},         64'(bus.oY),     64'(0));
    check({tag, ".oDone"},      64'(oDone),      64'(0));
    check({tag, ".oOverflow"},  64'(oOverflow),  64'(0));
    check({tag, ".oFifoLevel"}, 64'(oFifoLevel), 64'(0));
  endtask

  initial begin
    logic [23:0] p;
    logic [55:0] c0;
    bus.iValid = 1'b0;
    bus.iR = 8'h0;
    bus.iG = 8'h0;
    bus.iB = 8'h0;
    clearCap();
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset = 1'b1;

    pushRand(8, 8);
    check("A.levelPreload", 64'(oFifoLevel), 64'(8));
    clearCap();
    runFrame(1, 0, 0);
    checkFrame("A", 1);
    check("A.levelAfter", 64'(oFifoLevel), 64'(0));
    step(1'b0, 24'h0, 1'b0);
    check("A.idleAfterDone", 64'(bus.oValid), 64'(0));

    clearCap();
    runFrame(1, 1, 0);
    checkFrame("B", 0);

    pushRand(16, 16);
    check("C.levelPreload", 64'(oFifoLevel), 64'(16));
    clearCap();
    runFrame(1, 0, 1);
    checkFrame("C1", 1);
    clearCap();
    step(1'b0, 24'h0, 1'b0);
    check("C.noIdle.oValid", 64'(bus.oValid), 64'(1));
    check("C.noIdle.oX", 64'(bus.oX), 64'(0));
    check("C.noIdle.oY", 64'(bus.oY), 64'(0));
    runFrame(0, 0, 0);
    checkFrame("C2", 1);
    check("C.levelAfter", 64'(oFifoLevel), 64'(0));

    doReset();
    pushRand(20, 16);
    check("OV.overflow", 64'(oOverflow), 64'(1));
    check("OV.level", 64'(oFifoLevel), 64'(16));
    clearCap();
    runFrame(1, 0, 0);
    checkFrame("OV1", 1);
    clearCap();
    runFrame(1, 0, 0);
    checkFrame("OV2", 1);
    check("OV.levelDrained", 64'(oFifoLevel), 64'(0));
    check("OV.sticky", 64'(oOverflow), 64'(1));

    doReset();
    check("FULL.overflowCleared", 64'(oOverflow), 64'(0));
    pushRand(16, 16);
    check("FULL.levelPreload", 64'(oFifoLevel), 64'(16));
    clearCap();
    step(1'b0, 24'h0, 1'b1);
    waitDataEntry("FULL");
    for (int i = 0; i < W; i++) begin
      p = 24'($urandom);
      modelQ.push_back(p);
      step(1'b1, p, 1'b0);
    end
    check("FULL.levelHeld", 64'(oFifoLevel), 64'(16));
    check("FULL.noOverflow", 64'(oOverflow), 64'(0));
    runFrame(0, 0, 0);
    checkFrame("FULL", 1);
    check("FULL.levelAfter", 64'(oFifoLevel), 64'(16 - W * H + W));

    clearCap();
    step(1'b0, 24'h0, 1'b1);
    waitDataEntry("RST");
    step(1'b0, 24'h0, 1'b0);
    #2 reset = 1'b0;
    #1;
    checkAllZero("RST.async");
    @(posedge clk);
    #1 reset = 1'b1;
    modelQ.delete();
    pushRand(8, 8);
    clearCap();
    runFrame(1, 0, 0);
    c0 = (capQ.size() > 0) ? capQ[0] : 56'hFF_FFFF_FFFF_FFFF;
    check("RST.firstXY", 64'(c0[55:24]), 64'(0));
    checkFrame("RST", 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
